// File: rtl/disact_pk.sv
`default_nettype none
// ============================================================================
// Module   : disact_pk
// Summary  : Sparse activation distributor. Fetches a flag word, pops the
//            nonzero activations beat by beat and presents a packed or
//            scattered BLOCK_DEPTH-lane block to the PE array controller.
// Revision : 1.0 - initial release
// ============================================================================
module disact_pk #(
  parameter int BLOCK_DEPTH = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int RD_WORDS    = 4,
  parameter int ACT_ADDR_W  = 10,
  parameter int FLG_ADDR_W  = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               CTRLACT_PlsFetch,
  input  logic                               CTRLACT_Clr,
  input  logic                               CFG_Scatter,
  output logic                               DISACT_RdyAct,
  output logic [BLOCK_DEPTH-1:0]             DISACT_FlgAct,
  output logic [$clog2(BLOCK_DEPTH):0]       DISACT_NumAct,
  output logic [DATA_WIDTH*BLOCK_DEPTH-1:0]  DISACT_Act,
  input  logic                               GBFACT_Val,
  output logic                               GBFACT_EnRd,
  output logic [ACT_ADDR_W-1:0]              GBFACT_AddrRd,
  input  logic [DATA_WIDTH*RD_WORDS-1:0]     GBFACT_DatRd,
  input  logic                               GBFFLGACT_Val,
  output logic                               GBFFLGACT_EnRd,
  output logic [FLG_ADDR_W-1:0]              GBFFLGACT_AddrRd,
  input  logic [BLOCK_DEPTH-1:0]             GBFFLGACT_DatRd
);

  localparam int c_NUM_W = $clog2(BLOCK_DEPTH) + 1;
  localparam int c_IDX_W = $clog2(BLOCK_DEPTH);
  localparam int c_BEATS = BLOCK_DEPTH / RD_WORDS;
  localparam int c_CNT_W = $clog2(c_BEATS) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHKFLG  = 3'd1,
    LDFLG   = 3'd2,
    RDACT   = 3'd3,
    WAITGET = 3'd4
  } state_t;

  state_t                            r_state;
  logic [FLG_ADDR_W-1:0]             r_flgAddr;
  logic [ACT_ADDR_W-1:0]             r_actAddr;
  logic [c_CNT_W-1:0]                r_issued;
  logic [c_CNT_W-1:0]                r_recv;
  logic [c_CNT_W-1:0]                r_beats;
  logic [c_NUM_W-1:0]                r_num;
  logic [BLOCK_DEPTH-1:0]            r_flag;
  logic                              r_valDat;
  logic [DATA_WIDTH-1:0]             r_asm [BLOCK_DEPTH];
  logic                              r_rdy;
  logic [DATA_WIDTH*BLOCK_DEPTH-1:0] r_actOut;
  logic [BLOCK_DEPTH-1:0]            r_flgOut;
  logic [c_NUM_W-1:0]                r_numOut;

  logic                              w_flgEnRd;
  logic                              w_actEnRd;
  logic [c_NUM_W-1:0]                w_numIn;
  logic [c_CNT_W-1:0]                w_beatsIn;
  logic [DATA_WIDTH-1:0]             w_asmNext [BLOCK_DEPTH];
  logic [DATA_WIDTH*BLOCK_DEPTH-1:0] w_actOut;

  function automatic logic [c_NUM_W-1:0] popCount(input logic [BLOCK_DEPTH-1:0] v);
    logic [c_NUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < BLOCK_DEPTH; i++) s = s + c_NUM_W'(v[i]);
    return s;
  endfunction

  assign w_flgEnRd = (r_state == CHKFLG) && GBFFLGACT_Val;
  assign w_actEnRd = (r_state == RDACT) && GBFACT_Val && (r_issued < r_beats);
  assign w_numIn   = popCount(GBFFLGACT_DatRd);
  assign w_beatsIn = c_CNT_W'((int'(w_numIn) + RD_WORDS - 1) / RD_WORDS);

  // Assembly view including the beat landing this cycle, so the final beat
  // can be folded into the output registers without an extra cycle.
  always_comb begin
    for (int s = 0; s < BLOCK_DEPTH; s++) w_asmNext[s] = r_asm[s];
    if (r_valDat) begin
      for (int b = 0; b < c_BEATS; b++) begin
        if (r_recv == c_CNT_W'(b)) begin
          for (int k = 0; k < RD_WORDS; k++)
            w_asmNext[b*RD_WORDS + k] = GBFACT_DatRd[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    logic [c_NUM_W-1:0] w_rank;
    w_actOut = '0;
    w_rank   = '0;
    for (int i = 0; i < BLOCK_DEPTH; i++) begin
      if (CFG_Scatter) begin
        if (r_flag[i]) begin
          w_actOut[i*DATA_WIDTH +: DATA_WIDTH] = w_asmNext[w_rank[c_IDX_W-1:0]];
          w_rank = w_rank + c_NUM_W'(1);
        end
      end else if (c_NUM_W'(i) < r_num) begin
        w_actOut[i*DATA_WIDTH +: DATA_WIDTH] = w_asmNext[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_flgAddr <= '0;
      r_actAddr <= '0;
      r_issued  <= '0;
      r_recv    <= '0;
      r_beats   <= '0;
      r_num     <= '0;
      r_flag    <= '0;
      r_valDat  <= 1'b0;
      r_asm     <= '{default: '0};
      r_rdy     <= 1'b0;
      r_actOut  <= '0;
      r_flgOut  <= '0;
      r_numOut  <= '0;
    end else if (CTRLACT_Clr) begin
      r_state   <= IDLE;
      r_flgAddr <= '0;
      r_actAddr <= '0;
      r_issued  <= '0;
      r_recv    <= '0;
      r_beats   <= '0;
      r_num     <= '0;
      r_flag    <= '0;
      r_valDat  <= 1'b0;
      r_asm     <= '{default: '0};
      r_rdy     <= 1'b0;
      r_actOut  <= '0;
      r_flgOut  <= '0;
      r_numOut  <= '0;
    end else begin
      r_valDat <= w_actEnRd;
      r_asm    <= w_asmNext;
      if (w_flgEnRd) r_flgAddr <= r_flgAddr + FLG_ADDR_W'(1);
      if (w_actEnRd) begin
        r_actAddr <= r_actAddr + ACT_ADDR_W'(1);
        r_issued  <= r_issued + c_CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (CTRLACT_PlsFetch) r_state <= CHKFLG;
        end
        CHKFLG: begin
          if (w_flgEnRd) r_state <= LDFLG;
        end
        LDFLG: begin
          r_flag   <= GBFFLGACT_DatRd;
          r_num    <= w_numIn;
          r_beats  <= w_beatsIn;
          r_issued <= '0;
          r_recv   <= '0;
          if (w_numIn == '0) begin
            // Empty block: skip the activation buffer entirely.
            r_state  <= WAITGET;
            r_rdy    <= 1'b1;
            r_actOut <= '0;
            r_flgOut <= '0;
            r_numOut <= '0;
          end else begin
            r_state <= RDACT;
          end
        end
        RDACT: begin
          if (r_valDat) begin
            r_recv <= r_recv + c_CNT_W'(1);
            if (r_recv + c_CNT_W'(1) == r_beats) begin
              r_state  <= WAITGET;
              r_rdy    <= 1'b1;
              r_actOut <= w_actOut;
              r_flgOut <= r_flag;
              r_numOut <= r_num;
            end
          end
        end
        WAITGET: begin
          if (CTRLACT_PlsFetch) begin
            r_state <= CHKFLG;
            r_rdy   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign DISACT_RdyAct    = r_rdy;
  assign DISACT_FlgAct    = r_flgOut;
  assign DISACT_NumAct    = r_numOut;
  assign DISACT_Act       = r_actOut;
  assign GBFACT_EnRd      = w_actEnRd;
  assign GBFACT_AddrRd    = r_actAddr;
  assign GBFFLGACT_EnRd   = w_flgEnRd;
  assign GBFFLGACT_AddrRd = r_flgAddr;

endmodule
`default_nettype wire
